// File: rtl/rob_commit_ctrl.sv
// 16-entry reorder buffer controller: in-order allocate, CDB capture, in-order retire, flush on mispredict.
// Optional same-cycle operand forwarding is enabled by defining ROB_OPERAND_FWD_EN.
module rob_commit_ctrl #(
    parameter int ROB_SIZE = 16,
    parameter int ROB_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    output logic             issue_ready,
    output logic [ROB_W-1:0] issue_pos,
    output logic             update_valid,
    output logic [ROB_W-1:0] update_ROB_pos,
    output logic [4:0]       update_rd,
    input  logic             cdb_valid,
    input  logic [ROB_W-1:0] cdb_ROB_pos,
    input  logic [31:0]      cdb_val,
    input  logic             cdb_mispredict,
    input  logic [31:0]      cdb_target,
    output logic             commit_valid,
    output logic [ROB_W-1:0] commit_ROB_pos,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_val,
    output logic             flush,
    output logic [31:0]      flush_pc,
    input  logic [ROB_W-1:0] q1_pos,
    output logic             q1_ready,
    output logic [31:0]      q1_val,
    input  logic [ROB_W-1:0] q2_pos,
    output logic             q2_ready,
    output logic [31:0]      q2_val
);

    logic [ROB_W-1:0]    head, tail;
    logic [ROB_W:0]      count;
    logic [ROB_SIZE-1:0] busy, done, mis;
    logic [4:0]          rd_q  [ROB_SIZE];
    logic [31:0]         val_q [ROB_SIZE];
    logic [31:0]         tgt_q [ROB_SIZE];

    logic retire, flush_now, alloc, capture;

    assign retire    = rdy && (count != '0) && done[head];
    assign flush_now = retire && mis[head];
    assign capture   = rdy && cdb_valid && busy[cdb_ROB_pos];

    assign issue_ready    = (count != (ROB_W+1)'(ROB_SIZE));
    assign issue_pos      = tail;
    assign alloc          = issue_valid && issue_ready && rdy && !flush_now;
    assign update_valid   = alloc;
    assign update_ROB_pos = tail;
    assign update_rd      = issue_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            busy           <= '0;
            done           <= '0;
            mis            <= '0;
            commit_valid   <= 1'b0;
            commit_ROB_pos <= '0;
            commit_rd      <= '0;
            commit_val     <= '0;
            flush          <= 1'b0;
            flush_pc       <= '0;
        end else if (!rdy) begin
            commit_valid <= 1'b0;
            flush        <= 1'b0;
        end else begin
            commit_valid <= retire;
            flush        <= flush_now;
            if (retire) begin
                commit_ROB_pos <= head;
                commit_rd      <= rd_q[head];
                commit_val     <= val_q[head];
            end
            if (flush_now)
                flush_pc <= tgt_q[head];
            if (capture) begin
                done[cdb_ROB_pos] <= 1'b1;
                mis[cdb_ROB_pos]  <= cdb_mispredict;
            end
            // A flush discards everything younger than the branch, so the
            // whole buffer empties regardless of same-edge capture.
            if (flush_now) begin
                busy  <= '0;
                done  <= '0;
                mis   <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (retire) begin
                    busy[head] <= 1'b0;
                    done[head] <= 1'b0;
                    head       <= head + 1'b1;
                end
                if (alloc) begin
                    busy[tail] <= 1'b1;
                    done[tail] <= 1'b0;
                    mis[tail]  <= 1'b0;
                    tail       <= tail + 1'b1;
                end
                case ({alloc, retire})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Payload storage needs no reset; validity is tracked by busy/done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (capture) begin
                val_q[cdb_ROB_pos] <= cdb_val;
                tgt_q[cdb_ROB_pos] <= cdb_target;
            end
            if (alloc)
                rd_q[tail] <= issue_rd;
        end
    end

`ifdef ROB_OPERAND_FWD_EN
    function automatic logic [32:0] lookup(input logic [ROB_W-1:0] pos);
        logic [32:0] r;
        r = '0;
        if (busy[pos] && done[pos])
            r = {1'b1, val_q[pos]};
        else if (cdb_valid && cdb_ROB_pos == pos)
            r = {1'b1, cdb_val};
        return r;
    endfunction

    always_comb begin
        {q1_ready, q1_val} = lookup(q1_pos);
        {q2_ready, q2_val} = lookup(q2_pos);
    end
`else
    logic unused_q;
    assign unused_q = ^{q1_pos, q2_pos};
    assign q1_ready = 1'b0;
    assign q1_val   = '0;
    assign q2_ready = 1'b0;
    assign q2_val   = '0;
`endif

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Randomized bench for rob_commit_ctrl against an in-order queue model of the ROB.
module tb_rob_commit_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [3:0]  issue_pos;
    logic        update_valid;
    logic [3:0]  update_ROB_pos;
    logic [4:0]  update_rd;
    logic        cdb_valid;
    logic [3:0]  cdb_ROB_pos;
    logic [31:0] cdb_val;
    logic        cdb_mispredict;
    logic [31:0] cdb_target;
    logic        commit_valid;
    logic [3:0]  commit_ROB_pos;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic        flush;
    logic [31:0] flush_pc;
    logic [3:0]  q1_pos, q2_pos;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_val, q2_val;

    rob_commit_ctrl #(.ROB_SIZE(16), .ROB_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_ready(issue_ready), .issue_pos(issue_pos),
        .update_valid(update_valid), .update_ROB_pos(update_ROB_pos), .update_rd(update_rd),
        .cdb_valid(cdb_valid), .cdb_ROB_pos(cdb_ROB_pos), .cdb_val(cdb_val),
        .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
        .commit_valid(commit_valid), .commit_ROB_pos(commit_ROB_pos),
        .commit_rd(commit_rd), .commit_val(commit_val),
        .flush(flush), .flush_pc(flush_pc),
        .q1_pos(q1_pos), .q1_ready(q1_ready), .q1_val(q1_val),
        .q2_pos(q2_pos), .q2_ready(q2_ready), .q2_val(q2_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          pos;
        logic [4:0]  rd;
        bit          dn;
        logic [31:0] v;
        bit          m;
        logic [31:0] t;
    } ent_t;

    ent_t q[$];
    int   tail_m;
    int   total, bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [32:0] fwd_ref(input logic [3:0] p, input bit cv,
                                            input logic [3:0] cp, input logic [31:0] cval);
        foreach (q[i])
            if (q[i].pos == int'(p) && q[i].dn) return {1'b1, q[i].v};
        if (cv && cp == p) return {1'b1, cval};
        return '0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; issue_valid = 0; cdb_valid = 0; rdy = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete(); tail_m = 0;
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_commit_pos", commit_ROB_pos, 0);
        chk("rst_commit_rd", commit_rd, 0);
        chk("rst_commit_val", commit_val, 0);
        chk("rst_flush_pc", flush_pc, 0);
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_issue_pos", issue_pos, 0);
    endtask

    // One clock: drive, check combinational outputs, advance model, check registered outputs.
    task automatic cyc(input bit iv, input logic [4:0] ird, input bit cv, input logic [3:0] cp,
                       input logic [31:0] cval, input bit cm, input logic [31:0] ct,
                       input bit r, input logic [3:0] qp);
        bit full, ret, fl, up;
        ent_t c;
        logic [32:0] e1, e2;
        @(negedge clk);
        issue_valid = iv; issue_rd = ird; cdb_valid = cv; cdb_ROB_pos = cp; cdb_val = cval;
        cdb_mispredict = cm; cdb_target = ct; rdy = r; q1_pos = qp; q2_pos = ~qp;
        #1;
        full = (q.size() == 16);
        ret  = r && q.size() > 0 && q[0].dn;
        fl   = ret && q[0].m;
        up   = iv && !full && r && !fl;
        chk("issue_ready", issue_ready, !full);
        chk("issue_pos", issue_pos, tail_m);
        chk("update_valid", update_valid, up);
        if (up) begin
            chk("update_pos", update_ROB_pos, tail_m);
            chk("update_rd", update_rd, ird);
        end
`ifdef ROB_OPERAND_FWD_EN
        e1 = fwd_ref(qp, cv, cp, cval);
        e2 = fwd_ref(~qp, cv, cp, cval);
`else
        e1 = '0;
        e2 = '0;
`endif
        chk("q1_ready", q1_ready, e1[32]);
        chk("q1_val", q1_val, e1[31:0]);
        chk("q2_ready", q2_ready, e2[32]);
        chk("q2_val", q2_val, e2[31:0]);
        if (ret) c = q[0];
        if (r && cv)
            foreach (q[i])
                if (q[i].pos == int'(cp)) begin
                    q[i].dn = 1; q[i].v = cval; q[i].m = cm; q[i].t = ct;
                end
        if (ret) void'(q.pop_front());
        if (fl) begin q.delete(); tail_m = 0; end
        if (up) begin
            q.push_back('{pos: tail_m, rd: ird, dn: 0, v: 0, m: 0, t: 0});
            tail_m = (tail_m + 1) % 16;
        end
        @(posedge clk); #1;
        chk("commit_valid", commit_valid, ret);
        if (ret) begin
            chk("commit_pos", commit_ROB_pos, c.pos);
            chk("commit_rd", commit_rd, c.rd);
            chk("commit_val", commit_val, c.v);
        end
        chk("flush", flush, fl);
        if (fl) chk("flush_pc", flush_pc, c.t);
    endtask

    task automatic idle(input bit r);
        cyc(0, 0, 0, 0, 0, 0, 0, r, 0);
    endtask

    initial begin
        total = 0; bad = 0; tail_m = 0;
        rst = 1'b1; rdy = 1'b1; issue_valid = 0; issue_rd = 0; cdb_valid = 0;
        cdb_ROB_pos = 0; cdb_val = 0; cdb_mispredict = 0; cdb_target = 0;
        q1_pos = 0; q2_pos = 0;
        do_reset();

        // single issue, capture, retire
        cyc(1, 5, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 32'h1234, 0, 0, 1, 0);
        idle(1);
        idle(1);

        // fill to 16, hold issue while full, then drain one and wrap tail
        for (int i = 0; i < 18; i++) cyc(1, 5'(i + 1), 0, 0, 0, 0, 0, 1, 3);
        cyc(1, 9, 1, 4'(tail_m), 32'hAA, 0, 0, 1, 3);
        cyc(1, 9, 0, 0, 0, 0, 0, 1, 3);
        cyc(1, 10, 0, 0, 0, 0, 0, 1, 3);
        do_reset();

        // out-of-order completion, in-order commit
        for (int i = 0; i < 3; i++) cyc(1, 5'(i + 7), 0, 0, 0, 0, 0, 1, 0);
        for (int i = 2; i >= 0; i--) cyc(0, 0, 1, 4'(i), 32'(100 + i), 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) idle(1);

        // mispredicted branch retires with flush; same-edge issue dropped
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 5'(i + 1), 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 32'h55, 1, 32'h80, 1, 0);
        cyc(1, 12, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 13, 0, 0, 0, 0, 0, 1, 0);

        // rdy low holds a done head
        do_reset();
        cyc(1, 4, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 32'h77, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 3, 1, 0, 32'h99, 0, 0, 0, 0);
        idle(1);

        // operand query with same-cycle CDB bypass
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 5'(i + 1), 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 1, 3, 32'd7, 0, 0, 1, 3);
        idle(1);

        // random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit          iv, cv, cm, r;
            logic [3:0]  cp;
            if ($urandom_range(199) == 0) do_reset();
            iv = ($urandom_range(99) < 60);
            cv = ($urandom_range(99) < 50);
            cm = ($urandom_range(15) == 0);
            r  = ($urandom_range(9) != 0);
            if (q.size() > 0 && $urandom_range(3) != 0)
                cp = 4'(q[$urandom_range(q.size() - 1)].pos);
            else
                cp = 4'($urandom);
            cyc(iv, 5'($urandom), cv, cp, $urandom, cm, $urandom, r, 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
